// File: rtl/rv32_ex_muldiv.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN ends a multiply once the remaining multiplier magnitude is zero.
module rv32_ex_muldiv #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [31:0]       iw_in,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   rs1_data_in,
    input  logic [XLEN-1:0]   rs2_data_in,
    input  logic [REG_AW-1:0] wb_reg_in,
    input  logic              wb_en_in,
    output logic              out_valid,
    output logic [XLEN-1:0]   alu_out,
    output logic [31:0]       iw_out,
    output logic [XLEN-1:0]   pc_out,
    output logic [REG_AW-1:0] wb_reg_out,
    output logic              wb_en_out,
    output logic              illegal_out,
    output logic              stall_out
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} state_e;
    state_e state_q, state_d;

    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic              fast_q, illegal_q, neg_q;
    logic [XLEN-1:0]   fast_res_q, opb_q;
    logic [2*XLEN-1:0] opa_q, acc_q;
    logic [31:0]       iw_q;
    logic [XLEN-1:0]   pc_q;
    logic [REG_AW-1:0] wb_reg_q;
    logic              wb_en_q;
    logic              wb_en_res_q;

    logic [2:0]        f3;
    logic              is_m, accept, s1, s2, a_neg, b_neg, div_zero, div_ovf, take_fast;
    logic [XLEN-1:0]   mag_a, mag_b, fast_res;

    always_comb begin
        f3        = iw_in[14:12];
        is_m      = (iw_in[6:0] == 7'b0110011) && (iw_in[31:25] == 7'b0000001);
        accept    = in_valid && in_ready && !flush;
        s1        = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
        s2        = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
        a_neg     = s1 && rs1_data_in[XLEN-1];
        b_neg     = s2 && rs2_data_in[XLEN-1];
        mag_a     = a_neg ? -rs1_data_in : rs1_data_in;
        mag_b     = b_neg ? -rs2_data_in : rs2_data_in;
        div_zero  = (rs2_data_in == '0);
        div_ovf   = s2 && (rs1_data_in == MinNeg) && (rs2_data_in == '1);
        take_fast = !is_m || (f3[2] && (div_zero || div_ovf));
        if (!is_m)         fast_res = '0;
        else if (div_zero) fast_res = f3[1] ? rs1_data_in : '1;
        else               fast_res = f3[1] ? '0 : MinNeg;
    end

    logic            busy, done, mul_done, ge;
    logic [XLEN:0]   rem_sh, rem_nx;

    always_comb begin
        busy = (state_q == StMul) || (state_q == StDiv);
`ifdef MULDIV_EARLY_OUT_EN
        mul_done = (opb_q == '0);
`else
        mul_done = (cnt_q == CW'(XLEN));
`endif
        done   = fast_q || ((state_q == StMul) ? mul_done : (cnt_q == CW'(XLEN)));
        // Restoring divide: quotient develops in place of the dividend in opa_q.
        rem_sh = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
        ge     = (rem_sh >= {1'b0, opb_q});
        rem_nx = ge ? (rem_sh - {1'b0, opb_q}) : rem_sh;
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, result;

    always_comb begin
        prod   = neg_q ? -acc_q : acc_q;
        quo    = neg_q ? -opa_q[XLEN-1:0] : opa_q[XLEN-1:0];
        rmd    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        result = '0;
        if (illegal_q) begin
            result = '0;
        end else if (fast_q) begin
            result = fast_res_q;
        end else begin
            case (op_q)
                3'b000:                 result = prod[XLEN-1:0];
                3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
                3'b100, 3'b101:         result = quo;
                default:                result = rmd;
            endcase
        end
    end

    // Fast-path and non-M ops spend one cycle in StDiv so the result lands one edge after accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:       if (accept) state_d = (is_m && !f3[2]) ? StMul : StDiv;
            StMul, StDiv: if (done) state_d = StFin;
            StFin:        state_d = StIdle;
            default:      state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            op_q       <= '0;
            fast_q     <= 1'b0;
            illegal_q  <= 1'b0;
            neg_q      <= 1'b0;
            fast_res_q <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            iw_q       <= '0;
            pc_q       <= '0;
            wb_reg_q   <= '0;
            wb_en_q    <= 1'b0;
        end else if (accept) begin
            cnt_q      <= '0;
            op_q       <= f3;
            fast_q     <= take_fast;
            illegal_q  <= !is_m;
            neg_q      <= (f3[2] && f3[1]) ? a_neg : (a_neg ^ b_neg);
            fast_res_q <= fast_res;
            opa_q      <= {{XLEN{1'b0}}, mag_a};
            opb_q      <= mag_b;
            acc_q      <= '0;
            iw_q       <= iw_in;
            pc_q       <= pc_in;
            wb_reg_q   <= wb_reg_in;
            wb_en_q    <= wb_en_in;
        end else if (busy && !done) begin
            cnt_q <= cnt_q + CW'(1);
            if (state_q == StMul) begin
                if (opb_q[0]) acc_q <= acc_q + opa_q;
                opa_q <= opa_q << 1;
                opb_q <= opb_q >> 1;
            end else begin
                acc_q <= {{(XLEN-1){1'b0}}, rem_nx};
                opa_q <= {{XLEN{1'b0}}, opa_q[XLEN-2:0], ge};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_out     <= '0;
            iw_out      <= '0;
            pc_out      <= '0;
            wb_reg_out  <= '0;
            wb_en_res_q <= 1'b0;
            illegal_out <= 1'b0;
        end else if (busy && done && !flush) begin
            alu_out     <= result;
            iw_out      <= iw_q;
            pc_out      <= pc_q;
            wb_reg_out  <= wb_reg_q;
            wb_en_res_q <= wb_en_q && !illegal_q;
            illegal_out <= illegal_q;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StFin);
    assign stall_out = (state_q != StIdle) || (in_valid && !in_ready);
    assign wb_en_out = wb_en_res_q && out_valid;
endmodule
